// File: rtl/sort_engine_nb_pkg.sv
// Shared definitions for the odd-even transposition sorter: FSM encodings and
// a constant clog2 helper used to size the phase counter.
package sort_engine_nb_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StEven   = 2'd1;
  localparam logic [1:0] StOdd    = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned sort_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/sort_engine_nb_cmp_swap.sv
// Combinational compare-exchange cell. lo/hi are the pair as it should sit at
// positions i and i+1 after the exchange; equal values never swap.
module cmp_swap_nb #(
  parameter int unsigned W    = 4,
  parameter bit          DESC = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swap
);

  // Order the pair and flag whether an exchange happened.
  always_comb begin
    swap = DESC ? (a < b) : (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/sort_engine_nb.sv
// Self-sequencing odd-even transposition sorter. Loads N elements in parallel,
// sorts in place one compare-exchange phase per clock on start, exits early
// once two consecutive phases make no swaps, then pulses done for one cycle.
module sort_engine_nb
  import sort_engine_nb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 4,
  parameter bit          DESC = 1'b0,
  parameter int unsigned PW   = sort_clog2(N + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          start,
  input  logic [N*W-1:0] d_in,
  output logic [N*W-1:0] d_out,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] phase_cnt
);

  logic [N-1:0][W-1:0] arr_q, arr_d;
  logic [N-1:0][W-1:0] even_arr, odd_arr;
  logic [N/2-1:0]      even_swap, odd_swap;
  logic [1:0]          state_q, state_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic                prev_swap_q, prev_swap_d;
  logic                phase_swap;
  logic                terminate;

  // Even phase cells: pairs (0,1), (2,3), ...
  for (genvar p = 0; p < N / 2; p++) begin : g_even
    cmp_swap_nb #(
      .W    (W),
      .DESC (DESC)
    ) u_cell (
      .a    (arr_q[2*p]),
      .b    (arr_q[2*p+1]),
      .lo   (even_arr[2*p]),
      .hi   (even_arr[2*p+1]),
      .swap (even_swap[p])
    );
  end

  // Odd phase cells: pairs (1,2), ..., (N-3,N-2); none when N == 2.
  for (genvar p = 0; p < N / 2 - 1; p++) begin : g_odd
    cmp_swap_nb #(
      .W    (W),
      .DESC (DESC)
    ) u_cell (
      .a    (arr_q[2*p+1]),
      .b    (arr_q[2*p+2]),
      .lo   (odd_arr[2*p+1]),
      .hi   (odd_arr[2*p+2]),
      .swap (odd_swap[p])
    );
  end

  // End elements are untouched by an odd phase; spare swap bit keeps widths uniform.
  assign odd_arr[0]         = arr_q[0];
  assign odd_arr[N-1]       = arr_q[N-1];
  assign odd_swap[N/2-1]    = 1'b0;

  // Next-state, array and counter update.
  always_comb begin
    state_d     = state_q;
    arr_d       = arr_q;
    cnt_d       = cnt_q;
    prev_swap_d = prev_swap_q;
    phase_swap  = 1'b0;
    terminate   = 1'b0;
    case (state_q)
      StIdle: begin
        if (load) begin
          arr_d = d_in;
        end else if (start) begin
          cnt_d   = '0;
          state_d = StEven;
        end
      end
      StEven, StOdd: begin
        phase_swap  = (state_q == StEven) ? |even_swap : |odd_swap;
        arr_d       = (state_q == StEven) ? even_arr : odd_arr;
        cnt_d       = cnt_q + PW'(1);
        prev_swap_d = phase_swap;
        // prev_swap_q is only meaningful once a previous phase of this sort exists.
        terminate   = (cnt_d == PW'(N)) ||
                      ((cnt_d >= PW'(2)) && !phase_swap && !prev_swap_q);
        if (terminate) begin
          state_d = StFinish;
        end else begin
          state_d = (state_q == StEven) ? StOdd : StEven;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      arr_q       <= '0;
      cnt_q       <= '0;
      prev_swap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arr_q       <= arr_d;
      cnt_q       <= cnt_d;
      prev_swap_q <= prev_swap_d;
    end
  end

  assign d_out     = arr_q;
  assign phase_cnt = cnt_q;
  assign busy      = (state_q == StEven) || (state_q == StOdd);
  assign done      = (state_q == StFinish);

endmodule

// File: tb/tb_sort_engine_nb.sv
// Bench for sort_engine_nb: ascending and descending instances share inputs and
// are compared every cycle against a transaction-level model that precomputes
// the whole sort trajectory when a sort starts.
module tb_sort_engine_nb;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int NW = N * W;
  localparam int PW = 3;

  typedef logic [N:0][NW-1:0] traj_t;

  logic          clk = 1'b0;
  logic          clr, load, start;
  logic [NW-1:0] d_in;
  logic [NW-1:0] dout [2];
  logic          busy [2];
  logic          done [2];
  logic [PW-1:0] pcnt [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sort_engine_nb #(.N(N), .W(W), .DESC(1'b0)) u_asc (
    .clk       (clk),
    .clr       (clr),
    .load      (load),
    .start     (start),
    .d_in      (d_in),
    .d_out     (dout[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .phase_cnt (pcnt[0])
  );

  sort_engine_nb #(.N(N), .W(W), .DESC(1'b1)) u_desc (
    .clk       (clk),
    .clr       (clr),
    .load      (load),
    .start     (start),
    .d_in      (d_in),
    .d_out     (dout[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .phase_cnt (pcnt[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    logic [3:0] a0, a1, a2, a3;
    a0 = 4'(e0);
    a1 = 4'(e1);
    a2 = 4'(e2);
    a3 = 4'(e3);
    return {a3, a2, a1, a0};
  endfunction

  // Whole-sort reference: array after each phase and the terminating phase.
  function automatic void plan(input logic [NW-1:0] v, input bit desc,
                               output traj_t t, output int p);
    int a [N];
    int tmp;
    bit sw, prev;
    for (int i = 0; i < N; i++) a[i] = int'(v[i*W +: W]);
    t    = '0;
    t[0] = v;
    p    = 0;
    prev = 1'b1;
    for (int ph = 1; ph <= N; ph++) begin
      sw = 1'b0;
      for (int i = (ph % 2 == 1) ? 0 : 1; i + 1 < N; i += 2) begin
        if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
          tmp = a[i];
          a[i] = a[i+1];
          a[i+1] = tmp;
          sw = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) t[ph][i*W +: W] = a[i][W-1:0];
      p = ph;
      if (ph >= 2 && !sw && !prev) break;
      prev = sw;
    end
  endfunction

  // Model: 0 idle, 1 sorting, 2 done cycle.
  int            m_mode [2];
  int            m_j    [2];
  int            m_p    [2];
  int            m_cnt  [2];
  traj_t         m_traj [2];
  logic [NW-1:0] m_arr  [2];
  bit            m_busy [2];
  bit            m_done [2];

  always @(posedge clk) begin : model
    traj_t t;
    int    p;
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        m_mode[d] <= 0;
        m_arr[d]  <= '0;
        m_cnt[d]  <= 0;
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0;
      end else if (m_mode[d] == 0) begin
        if (load) begin
          m_arr[d] <= d_in;
        end else if (start) begin
          plan(m_arr[d], (d == 1), t, p);
          m_traj[d] <= t;
          m_p[d]    <= p;
          m_j[d]    <= 0;
          m_cnt[d]  <= 0;
          m_busy[d] <= 1'b1;
          m_mode[d] <= 1;
        end
      end else if (m_mode[d] == 1) begin
        m_j[d]   <= m_j[d] + 1;
        m_cnt[d] <= m_j[d] + 1;
        m_arr[d] <= m_traj[d][m_j[d] + 1];
        if (m_j[d] + 1 == m_p[d]) begin
          m_busy[d] <= 1'b0;
          m_done[d] <= 1'b1;
          m_mode[d] <= 2;
        end
      end else begin
        m_done[d] <= 1'b0;
        m_mode[d] <= 0;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d_out[%0d]", d), dout[d], m_arr[d]);
        chk($sformatf("busy[%0d]", d), busy[d], m_busy[d]);
        chk($sformatf("done[%0d]", d), done[d], m_done[d]);
        chk($sformatf("phase_cnt[%0d]", d), pcnt[d], m_cnt[d][PW-1:0]);
      end
    end
  end

  task automatic cyc(input logic c, input logic l, input logic s, input logic [NW-1:0] v);
    clr   = c;
    load  = l;
    start = s;
    d_in  = v;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy[0] || busy[1] || done[0] || done[1]) && c < budget) begin
      cyc(1'b0, 1'b0, 1'b0, NW'($urandom));
      c++;
    end
    if (c >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", c);
    end
  endtask

  initial begin
    traj_t t;
    int    p;
    int    n;

    clr   = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    d_in  = '0;

    // Pin the model with hand-derived values.
    plan(pack4(4, 3, 2, 1), 1'b0, t, p);
    chk("model_p_4321", p, 4);
    chk("model_traj2_4321", t[2], pack4(3, 1, 4, 2));
    plan(pack4(1, 2, 3, 4), 1'b0, t, p);
    chk("model_p_sorted", p, 2);
    plan(pack4(2, 2, 1, 1), 1'b0, t, p);
    chk("model_traj2_2211", t[2], pack4(2, 1, 2, 1));

    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    chk("reset_dout", dout[0], '0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_pcnt", pcnt[0], '0);

    // Reverse input: full N phases, done exactly four edges after start.
    cyc(1'b0, 1'b1, 1'b0, pack4(4, 3, 2, 1));
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("busy_at_k", busy[0], 1'b1);
    n = 0;
    while (!done[0] && n < 10) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      n++;
    end
    chk("done_edge_4321", n, 4);
    chk("sorted_4321", dout[0], pack4(1, 2, 3, 4));
    chk("pcnt_4321", pcnt[0], 4);
    wait_idle(20);

    // Already sorted: early exit after two phases; descending needs all four.
    cyc(1'b0, 1'b1, 1'b0, pack4(1, 2, 3, 4));
    cyc(1'b0, 1'b0, 1'b1, '0);
    wait_idle(20);
    chk("sorted_1234", dout[0], pack4(1, 2, 3, 4));
    chk("pcnt_1234", pcnt[0], 2);
    chk("desc_1234", dout[1], pack4(4, 3, 2, 1));
    chk("desc_pcnt_1234", pcnt[1], 4);

    // Duplicates.
    cyc(1'b0, 1'b1, 1'b0, pack4(2, 2, 1, 1));
    cyc(1'b0, 1'b0, 1'b1, '0);
    wait_idle(20);
    chk("sorted_2211", dout[0], pack4(1, 1, 2, 2));
    chk("pcnt_2211", pcnt[0], 4);

    // Clear mid-sort at k+2.
    cyc(1'b0, 1'b1, 1'b0, pack4(4, 3, 2, 1));
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("clr_dout", dout[0], '0);
    chk("clr_busy", busy[0], 1'b0);
    chk("clr_pcnt", pcnt[0], '0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, '0);

    // Load/start while busy are ignored.
    cyc(1'b0, 1'b1, 1'b0, pack4(4, 3, 2, 1));
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b1, pack4(9, 9, 9, 9));
    cyc(1'b0, 1'b1, 1'b1, pack4(9, 9, 9, 9));
    wait_idle(20);
    chk("busy_ignore", dout[0], pack4(1, 2, 3, 4));

    // Load wins over start in idle.
    cyc(1'b0, 1'b1, 1'b1, pack4(3, 1, 4, 2));
    chk("load_prio_dout", dout[0], pack4(3, 1, 4, 2));
    chk("load_prio_busy", busy[0], 1'b0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    wait_idle(20);
    chk("load_prio_sort", dout[0], pack4(1, 2, 3, 4));

    // Random traffic, including loads/starts during sorts and rare clears.
    repeat (800) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), NW'($urandom));
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    wait_idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
